// File: rtl/rsa_const_sched.sv
// Round-robin scheduler sharing one Montgomery-constant engine among NUM_REQ requesters, with watchdog and drain.
// Optional one-entry result cache when RSA_CONST_CACHE_EN is defined (cache hit answers without starting the engine).
module rsa_const_sched #(
    parameter int DATA_LENGTH    = 1024,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_mod,
    output logic                           rsp_valid,
    output logic                           rsp_err,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DATA_LENGTH-1:0]         rsp_r_r,
    output logic [DATA_LENGTH-1:0]         rsp_r_t,
    output logic                           busy,
    output logic                           eng_start,
    output logic [DATA_LENGTH-1:0]         eng_mod,
    input  logic                           eng_done,
    input  logic [DATA_LENGTH-1:0]         eng_r_r,
    input  logic [DATA_LENGTH-1:0]         eng_r_t
);

    typedef enum logic [2:0] {
        DRAIN  = 3'd0,
        IDLE   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [15:0]            wdog;
    logic                   wdog_tmo;
    logic [ID_W-1:0]        last_grant, grant_id, pick_id;
    logic                   pick_vld;
    logic                   err_pend;
    logic                   hit;
    logic [DATA_LENGTH-1:0] mod_arr [NUM_REQ];
    int                     idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mod
        assign mod_arr[i] = req_mod[i*DATA_LENGTH +: DATA_LENGTH];
    end

    // Search starts one past the last grant so nobody is served twice while another waits.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && req[ID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

`ifdef RSA_CONST_CACHE_EN
    logic                   cache_vld;
    logic [DATA_LENGTH-1:0] cache_mod, cache_r_r, cache_r_t;
    assign hit = cache_vld && (cache_mod == mod_arr[pick_id]);
`else
    assign hit = 1'b0;
`endif

    assign wdog_tmo  = (wdog == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_valid = (state == RESP);
    assign eng_start = (state == LAUNCH);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            DRAIN:   if (eng_done || wdog_tmo) state_nxt = IDLE;
            IDLE:    if (pick_vld) state_nxt = hit ? RESP : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (eng_done || wdog_tmo) state_nxt = RESP;
            RESP:    state_nxt = err_pend ? DRAIN : IDLE;
            default: state_nxt = DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRAIN;
            wdog       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            err_pend   <= 1'b0;
            eng_mod    <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            rsp_r_r    <= '0;
            rsp_r_t    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DRAIN: wdog <= wdog + 16'd1;
                IDLE: begin
                    if (pick_vld) begin
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        eng_mod    <= mod_arr[pick_id];
`ifdef RSA_CONST_CACHE_EN
                        if (hit) begin
                            rsp_id  <= pick_id;
                            rsp_err <= 1'b0;
                            rsp_r_r <= cache_r_r;
                            rsp_r_t <= cache_r_t;
                        end
`endif
                    end
                end
                LAUNCH: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 16'd1;
                    if (eng_done) begin
                        rsp_id  <= grant_id;
                        rsp_err <= 1'b0;
                        rsp_r_r <= eng_r_r;
                        rsp_r_t <= eng_r_t;
                    end else if (wdog_tmo) begin
                        rsp_id   <= grant_id;
                        rsp_err  <= 1'b1;
                        rsp_r_r  <= '0;
                        rsp_r_t  <= '0;
                        err_pend <= 1'b1;
                    end
                end
                RESP: begin
                    wdog     <= '0;
                    err_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef RSA_CONST_CACHE_EN
    // Only a successful engine run fills the cache; a timeout invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_mod <= '0;
            cache_r_r <= '0;
            cache_r_t <= '0;
        end else if (state == WAIT) begin
            if (eng_done) begin
                cache_vld <= 1'b1;
                cache_mod <= eng_mod;
                cache_r_r <= eng_r_r;
                cache_r_t <= eng_r_t;
            end else if (wdog_tmo) begin
                cache_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rsa_const_sched.sv
// Randomized bench for rsa_const_sched: engine model plus round-robin/cache reference model.
module tb_rsa_const_sched;

    localparam int DL  = 1024;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int TMO = 64;
`ifdef RSA_CONST_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DL-1:0] req_mod;
    logic             rsp_valid, rsp_err, busy, eng_start, eng_done;
    logic [IW-1:0]    rsp_id;
    logic [DL-1:0]    rsp_r_r, rsp_r_t, eng_mod, eng_r_r, eng_r_t;

    rsa_const_sched #(.DATA_LENGTH(DL), .NUM_REQ(NR), .ID_W(IW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mod(req_mod),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_id(rsp_id),
        .rsp_r_r(rsp_r_r), .rsp_r_t(rsp_r_t), .busy(busy),
        .eng_start(eng_start), .eng_mod(eng_mod), .eng_done(eng_done),
        .eng_r_r(eng_r_r), .eng_r_t(eng_r_t)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (low 192 bits)", tag, got[191:0], exp[191:0]);
        end
    endtask

    // R = 2^DL mod n after DL doublings, R^2 = 2^(2*DL) mod n after 2*DL doublings.
    task automatic mont(input logic [DL-1:0] n, output logic [DL-1:0] a, output logic [DL-1:0] b);
        logic [DL:0] r, nn;
        nn = {1'b0, n};
        r  = (n == 1) ? '0 : (DL+1)'(1);
        a  = '0;
        for (int k = 0; k < 2*DL; k++) begin
            r = r << 1;
            if (r >= nn) r = r - nn;
            if (k == DL-1) a = r[DL-1:0];
        end
        b = r[DL-1:0];
    endtask

    // Engine model: no reset, answers eng_lat cycles after the start cycle unless hung.
    int eng_lat  = 6;
    bit eng_hang = 1'b0;
    initial begin
        logic [DL-1:0] m, a, b;
        eng_done = 1'b0;
        eng_r_r  = '0;
        eng_r_t  = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && !eng_hang) begin
                m = eng_mod;
                mont(m, a, b);
                repeat (eng_lat) @(negedge clk);
                eng_r_r  = a;
                eng_r_t  = b;
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
                eng_r_r  = '0;
                eng_r_t  = '0;
            end
        end
    end

    typedef struct {
        int            id;
        logic          err;
        logic [DL-1:0] rr;
        logic [DL-1:0] rt;
        int            cyc;
    } rsp_t;

    rsp_t          rq[$];
    int            starts = 0;
    int            last_g = NR - 1;
    bit            cache_v = 1'b0;
    logic [DL-1:0] cache_m = '0;
    logic [DL-1:0] mods [NR];
    int            bat_id[$];
    int            bat_lat[$];
    logic [DL-1:0] bat_rr[$];
    logic [DL-1:0] bat_rt[$];

    // One cycle of requester behaviour: observe, and drop req right after its response.
    task automatic step();
        rsp_t r;
        @(negedge clk);
        if (rst_n) begin
            if (eng_start) starts++;
            if (rsp_valid) begin
                r.id = int'(rsp_id); r.err = rsp_err; r.rr = rsp_r_r; r.rt = rsp_r_t; r.cyc = cyc;
                rq.push_back(r);
                req[rsp_id] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output rsp_t r, output bit ok);
        int n = 0;
        while (rq.size() == 0 && n < budget) begin
            step();
            n++;
        end
        ok = (rq.size() != 0);
        check("rsp_arrived", 1024'(ok), 1024'(1));
        if (ok) r = rq.pop_front();
        else    r = '{id: -1, err: 1'b0, rr: '0, rt: '0, cyc: 0};
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
    endtask

    function automatic int next_rr(input int last, input logic [NR-1:0] p);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (p[IW'(i)]) return i;
        end
        return -1;
    endfunction

    function automatic logic [DL-1:0] rand_mod();
        logic [DL-1:0] m;
        for (int k = 0; k < DL/32; k++) m[k*32 +: 32] = $urandom;
        m[DL-1] = 1'b1;
        m[0]    = 1'b1;
        return m;
    endfunction

    // Asserts all requesters in mask at once and checks every response against the model.
    task automatic serve_batch(input logic [NR-1:0] mask, input bit expect_err);
        logic [NR-1:0] pend;
        logic [DL-1:0] a, b;
        int            id, t0, s0, exp_starts, w;
        bit            hit, ok;
        rsp_t          r;
        bat_id.delete(); bat_rr.delete(); bat_rt.delete(); bat_lat.delete();
        wait_idle(4*TMO, w);
        for (int i = 0; i < NR; i++) if (mask[i]) req_mod[i*DL +: DL] = mods[i];
        req        = req | mask;
        t0         = cyc;
        s0         = starts;
        exp_starts = 0;
        pend       = mask;
        while (pend != '0) begin
            id = next_rr(last_g, pend);
            pend[IW'(id)] = 1'b0;
            last_g = id;
            hit = CACHE_EN && cache_v && (cache_m == mods[id]) && !expect_err;
            if (!hit) begin
                exp_starts++;
                cache_v = !expect_err;
                cache_m = mods[id];
            end
            mont(mods[id], a, b);
            if (expect_err) begin a = '0; b = '0; end
            wait_rsp(2*TMO + 20, r, ok);
            if (ok) begin
                check("rsp_id", 1024'(r.id), 1024'(id));
                check("rsp_err", 1024'(r.err), 1024'(expect_err));
                check("rsp_r_r", r.rr, a);
                check("rsp_r_t", r.rt, b);
                bat_id.push_back(r.id); bat_rr.push_back(r.rr); bat_rt.push_back(r.rt);
                bat_lat.push_back(r.cyc - t0 + 1);
            end
        end
        check("eng_starts", 1024'(starts - s0), 1024'(exp_starts));
    endtask

    initial begin
        int            n, s0;
        logic [DL-1:0] ones;
        logic [NR-1:0] m;
        ones    = '1;
        rst_n   = 1'b0;
        req     = '0;
        req_mod = '0;
        for (int i = 0; i < NR; i++) mods[i] = '0;

        // Reset values, then DRAIN with an idle engine lasts exactly TMO cycles.
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 1024'(rsp_valid), '0);
        check("rst_rsp_err", 1024'(rsp_err), '0);
        check("rst_rsp_id", 1024'(rsp_id), '0);
        check("rst_rsp_r_r", rsp_r_r, '0);
        check("rst_eng_start", 1024'(eng_start), '0);
        check("rst_eng_mod", eng_mod, '0);
        check("rst_busy", 1024'(busy), 1024'(1));
        rst_n = 1'b1;
        wait_idle(4*TMO, n);
        check("drain_len", 1024'(n), 1024'(TMO));

        // Four simultaneous requests: order 0,1,2,3.
        mods[0] = 1024'd3; mods[1] = 1024'd5; mods[2] = 1024'd7; mods[3] = ones;
        serve_batch(4'b1111, 1'b0);
        for (int k = 0; k < 4 && k < bat_id.size(); k++) begin
            check("rr_order", 1024'(bat_id[k]), 1024'(k));
            check("rr_r_r", bat_rr[k], (k == 2) ? 1024'd2 : 1024'd1);
            check("rr_r_t", bat_rt[k], (k == 2) ? 1024'd4 : 1024'd1);
        end

        // Single request, mod 7: R=2, R^2=4, latency engine+3.
        mods[0] = 1024'd7;
        serve_batch(4'b0001, 1'b0);
        if (bat_id.size() > 0) begin
            check("single_r_r", bat_rr[0], 1024'd2);
            check("single_r_t", bat_rt[0], 1024'd4);
            check("single_lat", 1024'(bat_lat[0]), 1024'(eng_lat + 3));
        end

        // Hung engine: error response with zero results after the watchdog, then a full drain.
        eng_hang = 1'b1;
        mods[2]  = rand_mod();
        serve_batch(4'b0100, 1'b1);
        eng_hang = 1'b0;
        if (bat_lat.size() > 0) check("tmo_lat", 1024'(bat_lat[0]), 1024'(TMO + 3));
        wait_idle(4*TMO, n);
        check("tmo_drain_len", 1024'(n), 1024'(TMO + 1));
        mods[1] = rand_mod();
        serve_batch(4'b0010, 1'b0);

        // Reset mid-WAIT: outputs clear at once, late done only ends DRAIN, no response.
        eng_lat = 20;
        wait_idle(4*TMO, n);
        mods[3] = rand_mod();
        req_mod[3*DL +: DL] = mods[3];
        req[3] = 1'b1;
        s0 = starts;
        n  = 0;
        while (starts == s0 && n < 50) begin step(); n++; end
        check("t5_started", 1024'(starts - s0), 1024'(1));
        repeat (5) step();
        #2 rst_n = 1'b0;
        req = '0;
        #1;
        check("arst_rsp_valid", 1024'(rsp_valid), '0);
        check("arst_rsp_r_r", rsp_r_r, '0);
        check("arst_eng_start", 1024'(eng_start), '0);
        check("arst_eng_mod", eng_mod, '0);
        check("arst_busy", 1024'(busy), 1024'(1));
        last_g  = NR - 1;
        cache_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(4*TMO, n);
        check("late_done_drain", 1024'(n < TMO), 1024'(1));
        check("no_stale_rsp", 1024'(rq.size()), '0);
        eng_lat = 6;
        mods[3] = rand_mod();
        serve_batch(4'b1000, 1'b0);

        // Same modulus twice from requester 1: cache answers the second without the engine.
        mods[1] = 1024'd7;
        serve_batch(4'b0010, 1'b0);
        if (bat_lat.size() > 0) check("cache_first_lat", 1024'(bat_lat[0]), 1024'(eng_lat + 3));
        serve_batch(4'b0010, 1'b0);
        if (bat_lat.size() > 0)
            check("cache_second_lat", 1024'(bat_lat[0]), CACHE_EN ? 1024'd2 : 1024'(eng_lat + 3));

        // Random request sets, some moduli repeated.
        for (int it = 0; it < 8; it++) begin
            eng_lat = $urandom_range(1, 12);
            m = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0) mods[i] = 1024'd7;
                else mods[i] = rand_mod();
            serve_batch(m, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
